// File: rtl/clk_burst_ctrl.sv
// Generated-clock sequencer: start/stop handshake to glitch-free clk_out, programmable phase, LFSR jitter, bursts.
// First rise eff cycles after the start edge; no backpressure, start/stop are pulses honoured only in IDLE/RUN.
module clk_burst_ctrl #(
    parameter int          CNT_W     = 8,
    parameter int          BURST_W   = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   half_period,
    input  logic               jitter_en,
    input  logic [CNT_W-1:0]   jitter_mask,
    input  logic [BURST_W-1:0] burst_len,
    output logic               clk_out,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] edge_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W:0]     CNT_ONE  = 1;
    localparam logic [BURST_W-1:0] EDGE_ONE = 1;

    state_t             state;
    state_t             state_n;
    logic [CNT_W:0]     cnt;
    logic [CNT_W:0]     cnt_n;
    logic [CNT_W:0]     eff;
    logic [CNT_W:0]     reload;
    logic [CNT_W-1:0]   jit;
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_n;
    logic [15:0]        lfsr_step;
    logic [BURST_W-1:0] burst_lat;
    logic [BURST_W-1:0] burst_n;
    logic [BURST_W-1:0] edge_n;
    logic               clk_n;
    logic               done_n;
    logic               phase_end;
    logic               fall_due;
    logic               burst_hit;

    // Phase length is one bit wider than the operands so hp+jitter never wraps.
    always_comb begin
        jit       = jitter_en ? (lfsr[CNT_W-1:0] & jitter_mask) : '0;
        eff       = {1'b0, half_period} + {1'b0, jit};
        reload    = (eff == '0) ? '0 : (eff - CNT_ONE);
        lfsr_step = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        phase_end = (cnt == '0);
        fall_due  = phase_end && clk_out;
        burst_hit = (burst_lat != '0) && (edge_cnt == burst_lat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (stop && !clk_out) begin
                    state_n = IDLE;
                end else if (fall_due && (stop || burst_hit)) begin
                    state_n = IDLE;
                end else if (stop) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (fall_due) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        cnt_n   = cnt;
        clk_n   = clk_out;
        edge_n  = edge_cnt;
        lfsr_n  = lfsr;
        burst_n = burst_lat;
        done_n  = (state != IDLE) && (state_n == IDLE);
        case (state)
            IDLE: begin
                clk_n = 1'b0;
                if (start) begin
                    cnt_n   = reload;
                    edge_n  = '0;
                    burst_n = burst_len;
                    lfsr_n  = lfsr_step;
                end
            end
            RUN, DRAIN: begin
                // A stop while low ends the run at once, swallowing any rise due now.
                if ((state == RUN) && stop && !clk_out) begin
                    clk_n = 1'b0;
                end else if (phase_end) begin
                    clk_n  = !clk_out;
                    cnt_n  = reload;
                    lfsr_n = lfsr_step;
                    if (!clk_out) begin
                        edge_n = edge_cnt + EDGE_ONE;
                    end
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            default: clk_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            clk_out   <= 1'b0;
            done      <= 1'b0;
            edge_cnt  <= '0;
            lfsr      <= LFSR_SEED;
            burst_lat <= '0;
        end else begin
            cnt       <= cnt_n;
            clk_out   <= clk_n;
            done      <= done_n;
            edge_cnt  <= edge_n;
            lfsr      <= lfsr_n;
            burst_lat <= burst_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_clk_burst_ctrl.sv
// Directed bench for clk_burst_ctrl: expected clk_out edges and done pulses are queued
// at stimulus time and compared as the DUT produces them.
module tb_clk_burst_ctrl;

    localparam int K_RISE = 1;
    localparam int K_FALL = 2;
    localparam int K_DONE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [7:0]  half_period;
    logic        jitter_en;
    logic [7:0]  jitter_mask;
    logic [15:0] burst_len;
    logic        clk_out;
    logic        busy;
    logic        done;
    logic [15:0] edge_cnt;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    bit          mon_en = 1'b0;
    logic        prev  = 1'b0;
    logic [15:0] lfsr_m;

    typedef struct {
        int kind;
        int cyc;
        int ecnt;
    } ev_t;

    ev_t exp_q[$];

    clk_burst_ctrl #(
        .CNT_W     (8),
        .BURST_W   (16),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .half_period (half_period),
        .jitter_en   (jitter_en),
        .jitter_mask (jitter_mask),
        .burst_len   (burst_len),
        .clk_out     (clk_out),
        .busy        (busy),
        .done        (done),
        .edge_cnt    (edge_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input int c, input int n);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.ecnt = n;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", k, 0);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            check("event_cycle", cyc, e.cyc);
            if (k == K_RISE) check("edge_cnt_at_rise", edge_cnt, e.ecnt);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (clk_out !== prev) begin
                observe((clk_out === 1'b1) ? K_RISE : K_FALL);
                prev = clk_out;
            end
            if (done !== 1'b0) observe(K_DONE);
        end
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    task automatic plan_fixed(input int s, input int eff, input int rises);
        int t;
        t = s;
        for (int i = 0; i < 2 * rises; i++) begin
            t += eff;
            if (i % 2 == 0) push(K_RISE, t, i / 2 + 1);
            else            push(K_FALL, t, 0);
        end
        push(K_DONE, t, 0);
    endtask

    task automatic plan_jit(input int s, input int hp, input int mask, input int rises);
        int t;
        int eff;
        t = s;
        for (int i = 0; i < 2 * rises; i++) begin
            eff = hp + (int'(lfsr_m[7:0]) & mask);
            if (eff == 0) eff = 1;
            lfsr_m = lfsr_next(lfsr_m);
            t += eff;
            if (i % 2 == 0) push(K_RISE, t, i / 2 + 1);
            else            push(K_FALL, t, 0);
        end
        push(K_DONE, t, 0);
        lfsr_m = lfsr_next(lfsr_m);
    endtask

    task automatic goto_cyc(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic kick(output int s);
        s = cyc + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic settle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("run_completes", (exp_q.size() == 0 && busy === 1'b0), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int s;
        rst = 1'b1; start = 1'b0; stop = 1'b0; jitter_en = 1'b0;
        half_period = 8'd0; jitter_mask = 8'd0; burst_len = 16'd0;
        repeat (2) @(negedge clk);
        check("reset_clk_out", clk_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_edge_cnt", edge_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        prev = 1'b0;
        mon_en = 1'b1;

        // Burst of 2 at hp=3: rises 3,9 falls 6,12, done on 12.
        half_period = 8'd3; burst_len = 16'd2;
        kick(s);
        check("t1_busy_after_start", busy, 1);
        plan_fixed(s, 3, 2);
        goto_cyc(s + 12);
        check("t1_busy_last", busy, 1);
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_busy_drop", busy, 0);
        check("t1_edge_cnt", edge_cnt, 2);
        check("t1_clk_low", clk_out, 0);
        @(negedge clk);
        check("t1_done_one_cycle", done, 0);
        settle(50);

        // Free-run hp=2, stop low exactly when a rise is due.
        half_period = 8'd2; burst_len = 16'd0;
        kick(s);
        push(K_RISE, s + 2, 1);
        push(K_FALL, s + 4, 0);
        push(K_DONE, s + 6, 0);
        goto_cyc(s + 6);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t2_clk_low", clk_out, 0);
        check("t2_busy", busy, 0);
        check("t2_done", done, 1);
        repeat (3) @(negedge clk);
        check("t2_stays_low", clk_out, 0);
        settle(50);

        // Free-run hp=4, stop one cycle after a rise drains the high phase; start ignored.
        half_period = 8'd4;
        kick(s);
        push(K_RISE, s + 4, 1);
        push(K_FALL, s + 8, 0);
        push(K_RISE, s + 12, 2);
        push(K_FALL, s + 16, 0);
        push(K_DONE, s + 16, 0);
        goto_cyc(s + 13);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        start = 1'b1;
        check("t3_drain_busy", busy, 1);
        check("t3_drain_high", clk_out, 1);
        @(negedge clk);
        start = 1'b0;
        check("t3_drain_start_ignored", clk_out, 1);
        settle(50);
        check("t3_edge_cnt", edge_cnt, 2);

        // Stop while high with the fall due that same cycle.
        half_period = 8'd2;
        kick(s);
        push(K_RISE, s + 2, 1);
        push(K_FALL, s + 4, 0);
        push(K_DONE, s + 4, 0);
        goto_cyc(s + 4);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t3b_done", done, 1);
        check("t3b_busy", busy, 0);
        settle(50);

        // hp=0 behaves as eff=1.
        half_period = 8'd0; burst_len = 16'd3;
        kick(s);
        plan_fixed(s, 1, 3);
        settle(50);
        check("t4_edge_cnt", edge_cnt, 3);

        // Start while running is ignored.
        half_period = 8'd3; burst_len = 16'd2;
        kick(s);
        plan_fixed(s, 3, 2);
        goto_cyc(s + 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        settle(50);
        check("t6_edge_cnt", edge_cnt, 2);

        // start+stop together in IDLE starts a run.
        half_period = 8'd1; burst_len = 16'd1;
        s = cyc + 1;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("t6_start_stop_busy", busy, 1);
        plan_fixed(s, 1, 1);
        settle(50);

        // Reset mid-run while high: clk_out drops, no done.
        half_period = 8'd3; burst_len = 16'd0;
        kick(s);
        push(K_RISE, s + 3, 1);
        push(K_FALL, s + 5, 0);
        goto_cyc(s + 5);
        check("t6_high_before_rst", clk_out, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_clk_out", clk_out, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_edge_cnt", edge_cnt, 0);
        settle(50);

        // Jitter from the seed: hp=5, mask=03, then hp=255, mask=FF (no wrap).
        lfsr_m = 16'hACE1;
        jitter_en = 1'b1; jitter_mask = 8'h03; half_period = 8'd5; burst_len = 16'd4;
        kick(s);
        plan_jit(s, 5, 'h03, 4);
        settle(200);
        check("t5_edge_cnt", edge_cnt, 4);

        jitter_mask = 8'hFF; half_period = 8'd255; burst_len = 16'd1;
        kick(s);
        plan_jit(s, 255, 'hFF, 1);
        settle(1200);
        check("t4b_edge_cnt", edge_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
